wire_cut_checker: RTL and testbench

WIRE_CUT_CHECKER -- requirements
Module: wire_cut_checker

---
 rtl/wire_cut_checker_if.sv | 31 +++
 rtl/wire_cut_checker.sv | 162 ++++++++++++++++
 tb/tb_wire_cut_checker.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wire_cut_checker_if.sv
// Bundles the game-side signals of the wire-cut bomb checker.
//   master: drives wire_to_cut, cut_sw and pausesw, and observes the status outputs.
//   slave:  the checker itself.
// Status outputs:
//   state      0 IDLE, 1 ARMED, 2 DEFUSED, 3 EXPLODED
//   strikes    count of wrong cuts (saturating)
//   time_left  seconds remaining on the countdown
//   cut_mask   sticky record of which wires have been cut
//   defused    level flag, high while state is DEFUSED
//   exploded   level flag, high while state is EXPLODED
interface wire_cut_checker_if;
  logic [2:0] wire_to_cut;
  logic [4:0] cut_sw;
  logic       pausesw;
  logic [1:0] state;
  logic [1:0] strikes;
  logic [6:0] time_left;
  logic [4:0] cut_mask;
  logic       defused;
  logic       exploded;

  modport master (
    output wire_to_cut, cut_sw, pausesw,
    input  state, strikes, time_left, cut_mask, defused, exploded
  );

  modport slave (
    input  wire_to_cut, cut_sw, pausesw,
    output state, strikes, time_left, cut_mask, defused, exploded
  );
endinterface

// File: rtl/wire_cut_checker.sv
// Wire-cut bomb checker.
// The checker waits for the maze game to reveal a target wire, then judges
// each wire cut. Cutting exactly the target wire defuses the bomb. A wrong
// cut adds a strike. The bomb explodes when strikes reach MAX_STRIKES or
// when the countdown runs out.
// Ports:
//   clk  system clock (single clock domain)
//   rst  asynchronous active-high reset
//   bus  wire_cut_checker_if.slave, which carries the following signals:
//        wire_to_cut  target code
//        cut_sw       asynchronous wire switches
//        pausesw      freezes the countdown while high
//        state, strikes, time_left, cut_mask, defused, exploded  registered status outputs
module wire_cut_checker #(
  parameter int CLK_HZ      = 100000000,
  parameter int START_TIME  = 99,
  parameter int MAX_STRIKES = 3
) (
  input logic               clk,
  input logic               rst,
  wire_cut_checker_if.slave bus
);

  localparam int                 PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [1:0]         STRIKE_CAP = 2'(MAX_STRIKES);
  localparam logic [6:0]         TIME_INIT  = 7'(START_TIME);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } state_e;

  logic [4:0]         sync1_q, sync2_q, prev_q;
  state_e             state_q, state_d;
  logic [1:0]         strikes_q, strikes_d;
  logic [6:0]         time_left_q, time_left_d;
  logic [4:0]         cut_mask_q, cut_mask_d;
  logic [2:0]         target_q, target_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               defused_q, exploded_q;

  logic [4:0] new_cut;
  logic [4:0] mask_upd;
  logic [4:0] target_bit;
  logic [4:0] arm_bit;
  logic [2:0] arm_code;
  logic       terminal;
  logic       presc_hold;
  logic       tick;
  logic       correct_cut;
  logic       must_explode;
  logic [1:0] strikes_inc;
  logic [6:0] time_dec;

  // Two-flop synchronizer followed by a one-cycle-delayed copy used for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.cut_sw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    // Only rising edges on wires not yet recorded count as new cuts.
    // As a result, a switch that is reopened and closed again is ignored.
    new_cut    = sync2_q & ~prev_q & ~cut_mask_q;
    mask_upd   = cut_mask_q | new_cut;
    terminal   = (state_q == DEFUSED) || (state_q == EXPLODED);
    presc_hold = bus.pausesw || terminal;
    tick       = (presc_q == PRESC_LAST) && !presc_hold;

    presc_d = presc_q;
    if (!presc_hold) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    end

    // Codes 6 and 7 behave like "not yet solved".
    arm_code   = ((bus.wire_to_cut >= 3'd1) && (bus.wire_to_cut <= 3'd5)) ? bus.wire_to_cut : 3'd0;
    arm_bit    = (arm_code != 3'd0) ? (5'b00001 << (arm_code - 3'd1)) : 5'b00000;
    target_bit = (target_q != 3'd0) ? (5'b00001 << (target_q - 3'd1)) : 5'b00000;

    correct_cut = (state_q == ARMED) && (new_cut != 5'b0) && (new_cut == target_bit);
    // A correct cut beats an expired timer. A full strike count beats everything.
    must_explode = (strikes_q == STRIKE_CAP) || ((time_left_q == 7'd0) && !correct_cut);

    strikes_inc = (strikes_q == STRIKE_CAP) ? strikes_q : strikes_q + 2'd1;
    time_dec    = (tick && (time_left_q != 7'd0)) ? time_left_q - 7'd1 : time_left_q;
  end

  always_comb begin
    state_d     = state_q;
    strikes_d   = strikes_q;
    time_left_d = time_left_q;
    cut_mask_d  = cut_mask_q;
    target_d    = target_q;
    case (state_q)
      IDLE, ARMED: begin
        if (must_explode) begin
          state_d = EXPLODED;
        end else begin
          time_left_d = time_dec;
          cut_mask_d  = mask_upd;
          if (state_q == IDLE) begin
            // Any cut before the target is known is a strike, one per cycle.
            if (new_cut != 5'b0) begin
              strikes_d = strikes_inc;
            end
            if (arm_code != 3'd0) begin
              target_d = arm_code;
              state_d  = ((mask_upd & arm_bit) != 5'b0) ? EXPLODED : ARMED;
            end
          end else if (correct_cut) begin
            state_d = DEFUSED;
          end else if (new_cut != 5'b0) begin
            strikes_d = strikes_inc;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // The FSM and its counters. The level flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      strikes_q   <= '0;
      time_left_q <= TIME_INIT;
      cut_mask_q  <= '0;
      target_q    <= '0;
      presc_q     <= '0;
      defused_q   <= 1'b0;
      exploded_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      strikes_q   <= strikes_d;
      time_left_q <= time_left_d;
      cut_mask_q  <= cut_mask_d;
      target_q    <= target_d;
      presc_q     <= presc_d;
      defused_q   <= (state_d == DEFUSED);
      exploded_q  <= (state_d == EXPLODED);
    end
  end

  assign bus.state     = state_q;
  assign bus.strikes   = strikes_q;
  assign bus.time_left = time_left_q;
  assign bus.cut_mask  = cut_mask_q;
  assign bus.defused   = defused_q;
  assign bus.exploded  = exploded_q;

endmodule

// File: tb/tb_wire_cut_checker.sv
// Self-checking bench for wire_cut_checker.
// The bench runs directed vectors from a table, then hand-written timing sequences,
// then randomized play. Every cycle is also compared against a reference model of the game rules.
module tb_wire_cut_checker;
  localparam int CLK_HZ      = 10;
  localparam int START_TIME  = 5;
  localparam int MAX_STRIKES = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] wtc = '0;
  logic [4:0] cutSw = '0;
  logic       pause = 1'b0;

  wire_cut_checker_if bus ();

  assign bus.wire_to_cut = wtc;
  assign bus.cut_sw      = cutSw;
  assign bus.pausesw     = pause;

  wire_cut_checker #(
    .CLK_HZ(CLK_HZ),
    .START_TIME(START_TIME),
    .MAX_STRIKES(MAX_STRIKES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: game state in plain integers.
  // The model keeps a short history of the switch samples taken at each clock edge.
  int mState, mStrikes, mTime, mMask, mTarget, mActive;
  int cutHist[$];

  typedef struct {
    bit         doRst;
    logic [2:0] wtc;
    logic [4:0] cut;
    int         cycles;
    int         expState;
    int         expStrikes;
    int         expMask;
    int         expTime;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit r, input int w, input int c, input int n,
                        input int es, input int ek, input int em, input int et);
    vec_t v;
    v.doRst      = r;
    v.wtc        = 3'(w);
    v.cut        = 5'(c);
    v.cycles     = n;
    v.expState   = es;
    v.expStrikes = ek;
    v.expMask    = em;
    v.expTime    = et;
    vecs.push_back(v);
  endtask

  task automatic checkOne(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mState   = 0;
    mStrikes = 0;
    mTime    = START_TIME;
    mMask    = 0;
    mTarget  = 0;
    mActive  = 0;
    cutHist.delete();
  endtask

  // One clock edge of the game rules. A switch sampled high at edge k is acted on at edge k+2.
  task automatic modelStep();
    int  sz, older, oldest, newCuts, tbit, armCode;
    bit  terminal, held, tick, correct;
    cutHist.push_back(int'(cutSw));
    if (cutHist.size() > 4) void'(cutHist.pop_front());
    sz      = cutHist.size();
    older   = (sz >= 3) ? cutHist[sz-3] : 0;
    oldest  = (sz >= 4) ? cutHist[sz-4] : 0;
    newCuts = older & ~oldest & ~mMask & 31;
    terminal = (mState >= 2);
    held     = pause || terminal;
    tick     = !held && ((mActive % CLK_HZ) == CLK_HZ - 1);
    if (!held) mActive++;
    tbit    = (mTarget != 0) ? (1 << (mTarget - 1)) : 0;
    correct = (mState == 1) && (newCuts != 0) && (newCuts == tbit);
    if (terminal) begin
    end else if (mStrikes >= MAX_STRIKES || (mTime == 0 && !correct)) begin
      mState = 3;
    end else begin
      if (tick && mTime > 0) mTime--;
      mMask = mMask | newCuts;
      if (mState == 0) begin
        if (newCuts != 0 && mStrikes < MAX_STRIKES) mStrikes++;
        armCode = (wtc >= 1 && wtc <= 5) ? int'(wtc) : 0;
        if (armCode != 0) begin
          mTarget = armCode;
          mState  = ((mMask >> (armCode - 1)) & 1) ? 3 : 1;
        end
      end else if (correct) begin
        mState = 2;
      end else if (newCuts != 0 && mStrikes < MAX_STRIKES) begin
        mStrikes++;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOne({tag, ".state"},    int'(bus.state),     mState);
    checkOne({tag, ".strikes"},  int'(bus.strikes),   mStrikes);
    checkOne({tag, ".time"},     int'(bus.time_left), mTime);
    checkOne({tag, ".mask"},     int'(bus.cut_mask),  mMask);
    checkOne({tag, ".defused"},  int'(bus.defused),   (mState == 2) ? 1 : 0);
    checkOne({tag, ".exploded"}, int'(bus.exploded),  (mState == 3) ? 1 : 0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkModel("model");
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v     = vecs[idx];
    wtc   = v.wtc;
    cutSw = v.cut;
    pause = 1'b0;
    if (v.doRst) doReset();
    repeat (v.cycles) stepCycle();
    checkOne($sformatf("vec%0d.state", idx),   int'(bus.state),     v.expState);
    checkOne($sformatf("vec%0d.strikes", idx), int'(bus.strikes),   v.expStrikes);
    checkOne($sformatf("vec%0d.mask", idx),    int'(bus.cut_mask),  v.expMask);
    checkOne($sformatf("vec%0d.time", idx),    int'(bus.time_left), v.expTime);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    // Fields: reset, wire_to_cut, cut_sw, cycles, then expected state, strikes, mask and time.
    addVec(1, 3, 5'b00000, 1, 1, 0, 5'b00000, 5);
    addVec(0, 3, 5'b00100, 2, 1, 0, 5'b00000, 5);
    addVec(0, 3, 5'b00100, 1, 2, 0, 5'b00100, 5);
    addVec(1, 2, 5'b00000, 1, 1, 0, 5'b00000, 5);
    addVec(0, 2, 5'b00001, 3, 1, 1, 5'b00001, 5);
    addVec(0, 2, 5'b01001, 3, 1, 2, 5'b01001, 5);
    addVec(0, 2, 5'b11001, 3, 1, 3, 5'b11001, 4);
    addVec(0, 2, 5'b11001, 1, 3, 3, 5'b11001, 4);
    addVec(1, 1, 5'b00000, 1, 1, 0, 5'b00000, 5);
    addVec(0, 1, 5'b00011, 3, 1, 1, 5'b00011, 5);
    addVec(1, 0, 5'b01000, 2, 0, 0, 5'b00000, 5);
    addVec(0, 0, 5'b01000, 1, 0, 1, 5'b01000, 5);
    addVec(0, 4, 5'b01000, 1, 3, 1, 5'b01000, 5);
    addVec(0, 4, 5'b01000, 5, 3, 1, 5'b01000, 5);
    addVec(1, 6, 5'b00000, 2, 0, 0, 5'b00000, 5);
    addVec(0, 7, 5'b00000, 1, 0, 0, 5'b00000, 5);
    addVec(0, 5, 5'b00000, 1, 1, 0, 5'b00000, 5);
    addVec(0, 2, 5'b10000, 3, 2, 0, 5'b10000, 5);

    @(negedge clk);
    checkOne("reset.state", int'(bus.state), 0);
    checkOne("reset.time",  int'(bus.time_left), START_TIME);
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    // Free-running countdown with no target and no cuts.
    wtc = 0; cutSw = 0; pause = 0;
    doReset();
    for (int k = 1; k <= 52; k++) begin
      stepCycle();
      checkOne($sformatf("count%0d.time", k), int'(bus.time_left), (k >= 50) ? 0 : 5 - k / 10);
      checkOne($sformatf("count%0d.state", k), int'(bus.state), (k >= 51) ? 3 : 0);
    end

    // The pause switch holds the prescaler mid-second.
    doReset();
    repeat (5) stepCycle();
    pause = 1;
    repeat (30) stepCycle();
    checkOne("pause.time_held", int'(bus.time_left), 5);
    pause = 0;
    repeat (4) stepCycle();
    checkOne("pause.time_resume", int'(bus.time_left), 5);
    stepCycle();
    checkOne("pause.time_tick", int'(bus.time_left), 4);

    // A correct cut lands on the same edge that the timer reaches zero.
    wtc = 1;
    doReset();
    repeat (47) stepCycle();
    cutSw = 5'b00001;
    repeat (3) stepCycle();
    checkOne("race.state", int'(bus.state), 2);
    checkOne("race.time",  int'(bus.time_left), 0);
    stepCycle();
    checkOne("race.state_hold", int'(bus.state), 2);

    // Defuse with 2 seconds left, then reset out of the terminal state.
    wtc = 3; cutSw = 0;
    doReset();
    repeat (30) stepCycle();
    cutSw = 5'b00100;
    repeat (3) stepCycle();
    checkOne("defuse.state", int'(bus.state), 2);
    checkOne("defuse.time",  int'(bus.time_left), 2);
    repeat (10) stepCycle();
    checkOne("defuse.time_frozen", int'(bus.time_left), 2);
    rst = 1'b1;
    #1;
    checkOne("async.state",   int'(bus.state), 0);
    checkOne("async.time",    int'(bus.time_left), 5);
    checkOne("async.strikes", int'(bus.strikes), 0);
    checkOne("async.mask",    int'(bus.cut_mask), 0);
    checkOne("async.defused", int'(bus.defused), 0);
    cutSw = 0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Randomized play against the reference model.
    for (int run = 0; run < 20; run++) begin
      wtc   = 0;
      pause = 0;
      cutSw = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
      doReset();
      for (int cyc = 0; cyc < 150; cyc++) begin
        if ($urandom_range(0, 7) == 0) begin
          int b;
          b = int'($urandom_range(0, 4));
          cutSw[b] = ~cutSw[b];
        end
        if ($urandom_range(0, 24) == 0) wtc = 3'($urandom_range(0, 7));
        pause = ($urandom_range(0, 9) == 0);
        stepCycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
